// File: rtl/data_mem_responder.sv
// Word-organised data RAM for the memory unit's bus. It has a pipelined read path,
// flags illegal addresses and keeps saturating write/read access counters.
module data_mem_responder #(
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   input  logic        wr_en,
   input  logic        rd_en,
   output logic [31:0] mem_data_read,
   output logic        rd_valid,
   output logic        addr_err,
   output logic [15:0] wr_count,
   output logic [15:0] rd_count
);

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("data_mem_responder: READ_LATENCY must be in 1..4");
   end

   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [33:0] SPAN = 34'(DEPTH) << 2;

   logic [31:0] mem [DEPTH];

   logic [31:0] offset;
   logic [AW-1:0] mem_idx;
   logic        legal;
   logic        wr_ok;
   logic        rd_ok;
   logic [31:0] rd_word;

   logic [READ_LATENCY-1:0] pipe_v;
   logic [31:0]             pipe_d [READ_LATENCY];
   logic [31:0]             hold_q;

   // Comparing the full offset against 4*DEPTH is the same test as index >= DEPTH.
   assign offset  = addr - BASE_ADDR;
   assign legal   = (addr[1:0] == 2'b00) && ({2'b00, offset} < SPAN);
   assign mem_idx = offset[AW+1:2];
   assign wr_ok   = wr_en & legal;
   assign rd_ok   = rd_en & legal;

   // Reads and writes share one address, so write-first only needs to check wr_ok.
   assign rd_word = !rd_ok ? '0 : (wr_ok ? wr_data : mem[mem_idx]);

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[mem_idx] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_v   <= '0;
         for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            pipe_d[i] <= '0;
         end
         hold_q   <= '0;
         addr_err <= 1'b0;
         wr_count <= '0;
         rd_count <= '0;
      end else begin
         pipe_v[0] <= rd_en;
         pipe_d[0] <= rd_word;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
         if (pipe_v[READ_LATENCY-1]) begin
            hold_q <= pipe_d[READ_LATENCY-1];
         end
         addr_err <= (rd_en | wr_en) & ~legal;
         if (wr_ok && wr_count != '1) begin
            wr_count <= wr_count + 16'd1;
         end
         if (rd_ok && rd_count != '1) begin
            rd_count <= rd_count + 16'd1;
         end
      end
   end

   // The last stage drives the output directly and hold_q keeps it between strobes.
   assign rd_valid      = pipe_v[READ_LATENCY-1];
   assign mem_data_read = rd_valid ? pipe_d[READ_LATENCY-1] : hold_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench. Two responders (latency 1 / base 0 and latency 4 /
// base 0x100) share one stimulus and are checked against a queue-based reference model.
module tb_data_mem_responder;

   localparam int unsigned DEPTH = 1024;

   typedef struct {
      int unsigned due;
      logic [31:0] data;
   } rd_item_t;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic        wr_en;
   logic        rd_en;

   logic [31:0] rdata [2];
   logic [1:0]  rv;
   logic [1:0]  ae;
   logic [15:0] wc [2];
   logic [15:0] rc [2];

   int unsigned n_vec;
   int unsigned n_err;
   int unsigned cyc;

   logic [31:0] mm     [2][DEPTH];
   rd_item_t    q      [2][$];
   logic [31:0] last_m [2];
   logic        err_m  [2];
   logic [15:0] wc_m   [2];
   logic [15:0] rc_m   [2];

   data_mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(1), .BASE_ADDR(32'h0000_0000)) dut_a (
      .clk(clk), .reset(reset), .addr(addr), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
      .mem_data_read(rdata[0]), .rd_valid(rv[0]), .addr_err(ae[0]), .wr_count(wc[0]), .rd_count(rc[0])
   );

   data_mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(4), .BASE_ADDR(32'h0000_0100)) dut_b (
      .clk(clk), .reset(reset), .addr(addr), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
      .mem_data_read(rdata[1]), .rd_valid(rv[1]), .addr_err(ae[1]), .wr_count(wc[1]), .rd_count(rc[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int unsigned lat_of(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   function automatic logic [31:0] base_of(input int k);
      return (k == 0) ? 32'h0000_0000 : 32'h0000_0100;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      for (int k = 0; k < 2; k++) begin
         logic exp_v;
         exp_v = (q[k].size() > 0) && (q[k][0].due == cyc);
         if (exp_v) last_m[k] = q[k].pop_front().data;
         check_eq($sformatf("rd_valid[%0d] cyc %0d", k, cyc), {31'd0, rv[k]}, {31'd0, exp_v});
         check_eq($sformatf("mem_data_read[%0d] cyc %0d", k, cyc), rdata[k], last_m[k]);
         check_eq($sformatf("addr_err[%0d] cyc %0d", k, cyc), {31'd0, ae[k]}, {31'd0, err_m[k]});
         check_eq($sformatf("wr_count[%0d] cyc %0d", k, cyc), {16'd0, wc[k]}, {16'd0, wc_m[k]});
         check_eq($sformatf("rd_count[%0d] cyc %0d", k, cyc), {16'd0, rc[k]}, {16'd0, rc_m[k]});
      end
   endtask

   // Applies the currently driven inputs for one clock edge and checks the result.
   task automatic tick();
      int unsigned e;
      e = cyc + 1;
      for (int k = 0; k < 2; k++) begin
         logic [31:0] off;
         int unsigned idx;
         logic        ok;
         off = addr - base_of(k);
         idx = off >> 2;
         ok  = (addr[1:0] == 2'b00) && (idx < DEPTH);
         if (rd_en) begin
            q[k].push_back('{e + lat_of(k) - 1, ok ? (wr_en ? wr_data : mm[k][idx]) : 32'h0});
            if (ok && rc_m[k] < 16'hFFFF) rc_m[k]++;
         end
         if (wr_en && ok) begin
            mm[k][idx] = wr_data;
            if (wc_m[k] < 16'hFFFF) wc_m[k]++;
         end
         err_m[k] = (rd_en || wr_en) && !ok;
      end
      @(posedge clk);
      #1;
      cyc = e;
      check_outputs();
   endtask

   task automatic op(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
      wr_en   = we;
      rd_en   = re;
      addr    = a;
      wr_data = d;
      tick();
   endtask

   // Called just after a rising edge; asserts reset mid-cycle.
   task automatic do_reset();
      wr_en = 1'b0;
      rd_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         check_eq($sformatf("rst rd_valid[%0d]", k), {31'd0, rv[k]}, 32'h0);
         check_eq($sformatf("rst mem_data_read[%0d]", k), rdata[k], 32'h0);
         check_eq($sformatf("rst addr_err[%0d]", k), {31'd0, ae[k]}, 32'h0);
         check_eq($sformatf("rst wr_count[%0d]", k), {16'd0, wc[k]}, 32'h0);
         check_eq($sformatf("rst rd_count[%0d]", k), {16'd0, rc[k]}, 32'h0);
         q[k].delete();
         last_m[k] = '0;
         err_m[k]  = 1'b0;
         wc_m[k]   = '0;
         rc_m[k]   = '0;
      end
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      n_vec = 0;
      n_err = 0;
      cyc   = 0;
      reset = 1'b0;
      addr = '0; wr_data = '0; wr_en = 1'b0; rd_en = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Fill every legal word of both instances so later reads are defined.
      for (int unsigned i = 0; i < 32'h10FC; i += 4) op(1'b1, 1'b0, i, $urandom);
      op(1'b1, 1'b0, 32'h10FC, $urandom);

      op(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
      op(1'b0, 1'b1, 32'h10, 32'h0);
      check_eq("p1 rd_valid", {31'd0, rv[0]}, 32'h1);
      check_eq("p1 data", rdata[0], 32'hDEAD_BEEF);

      op(1'b1, 1'b0, 32'h100, 32'h1111_1111);
      op(1'b1, 1'b0, 32'h104, 32'h2222_2222);
      op(1'b1, 1'b0, 32'h108, 32'h3333_3333);
      op(1'b0, 1'b1, 32'h100, 32'h0);
      op(1'b0, 1'b1, 32'h104, 32'h0);
      op(1'b0, 1'b1, 32'h108, 32'h0);
      op(1'b0, 1'b0, 32'h0, 32'h0);
      check_eq("p2 first", rdata[1], 32'h1111_1111);
      op(1'b0, 1'b0, 32'h0, 32'h0);
      check_eq("p2 second", rdata[1], 32'h2222_2222);
      op(1'b0, 1'b0, 32'h0, 32'h0);
      check_eq("p2 third", rdata[1], 32'h3333_3333);

      op(1'b1, 1'b0, 32'h6, 32'hBAD0_BAD0);
      check_eq("p3 misaligned err", {31'd0, ae[0]}, 32'h1);
      op(1'b0, 1'b1, 32'h1000, 32'h0);
      check_eq("p3 range err", {31'd0, ae[0]}, 32'h1);
      check_eq("p3 range data", rdata[0], 32'h0);
      op(1'b0, 1'b1, 32'h4, 32'h0);
      check_eq("p3 err clears", {31'd0, ae[0]}, 32'h0);

      op(1'b1, 1'b0, 32'h20, 32'h0);
      op(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D);
      check_eq("p4 write-first", rdata[0], 32'hCAFE_F00D);

      op(1'b0, 1'b1, 32'h200, 32'h0);
      op(1'b0, 1'b0, 32'h0, 32'h0);
      do_reset();
      for (int i = 0; i < 6; i++) op(1'b0, 1'b0, 32'h0, 32'h0);
      op(1'b0, 1'b1, 32'h10, 32'h0);
      check_eq("p5 preserved", rdata[0], 32'hDEAD_BEEF);

      for (int i = 0; i < 2000; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5, 6: a = 32'($urandom_range(0, 32'h47F)) << 2;
            7:                   a = (32'($urandom_range(0, 32'h47F)) << 2) | 32'($urandom_range(1, 3));
            8:                   a = $urandom;
            default:             a = 32'hFFFF_FFFC;
         endcase
         op(1'($urandom), 1'($urandom), a, $urandom);
      end

      for (int i = 0; i < 65540; i++) begin
         op(1'b1, 1'b0, 32'h100 + (32'($urandom_range(0, 959)) << 2), $urandom);
      end
      check_eq("p6 saturated", {16'd0, wc[0]}, 32'h0000_FFFF);
      op(1'b0, 1'b1, 32'h200, 32'h0);
      repeat (4) op(1'b0, 1'b0, 32'h0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
